// File: rtl/uart_tx_fifo_ctrl.sv
// uart_tx_fifo_ctrl
// Two byte requesters share one UART TX FIFO through a round-robin write
// arbiter. A four-state read sequencer pops one byte per transmitter frame.
// Occupancy is tracked locally and capped at FIFO_DEPTH-1, so the FIFO's own
// full flag is never consulted. fifo_empty is used only as a sanity check.

// Per-requester accept logic. A requester wins when it is the only one
// asking, or when both ask and the round-robin pointer favours it.
module uart_tx_req_lane (
    input  logic valid,
    input  logic other_valid,
    input  logic preferred,
    input  logic space,
    output logic ready
);
    // Ready depends only on the valids, the pointer and space, never on data.
    always_comb ready = space & valid & (~other_valid | preferred);
endmodule

module uart_tx_fifo_ctrl #(
    parameter  int DATA_WIDTH = 8,
    parameter  int FIFO_DEPTH = 16,
    localparam int LVL_W      = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tx_en,
    input  logic                  req0_valid,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_ready,
    output logic                  fifo_wr_en,
    output logic [DATA_WIDTH-1:0] fifo_din,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_empty,
    output logic                  tx_start,
    output logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_busy,
    output logic [LVL_W-1:0]      level,
    output logic                  err
);
    localparam int              NUM_REQ = 2;
    localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {IDLE, START, ACK, BUSY} state_t;

    state_t                              state, state_nxt;
    logic                                rr_ptr;
    logic                                space;
    logic                                pop_go;
    logic [NUM_REQ-1:0]                  req_valid;
    logic [NUM_REQ-1:0]                  ready_vec;

    assign req_valid = {req1_valid, req0_valid};

    // Readies are held low while reset is asserted, even with an empty FIFO.
    always_comb space = reset & (level < LVL_MAX);

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        uart_tx_req_lane u_lane (
            .valid       (req_valid[i]),
            .other_valid (req_valid[NUM_REQ-1-i]),
            .preferred   (rr_ptr == 1'(i)),
            .space       (space),
            .ready       (ready_vec[i])
        );
    end

    // Write side: ready already implies valid, so a ready is a fire.
    always_comb begin
        req0_ready = ready_vec[0];
        req1_ready = ready_vec[1];
        fifo_wr_en = |ready_vec;
        fifo_din   = ready_vec[1] ? req1_data : req0_data;
    end

    // Round-robin pointer hands priority to the other requester after a fire.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)          rr_ptr <= 1'b0;
        else if (fifo_wr_en) rr_ptr <= ready_vec[0];
    end

    // Occupancy: +1 per write, -1 per pop; write and pop together cancel.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            level <= '0;
        else if (fifo_wr_en && !fifo_rd_en && level != LVL_MAX)
            level <= level + 1'b1;
        else if (!fifo_wr_en && fifo_rd_en && level != '0)
            level <= level - 1'b1;
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state and pop decision. A pop is only taken from IDLE, so the
    // earliest follow-on pop is one full IDLE cycle after the frame ends.
    always_comb begin
        state_nxt = state;
        pop_go    = 1'b0;
        case (state)
            IDLE: begin
                if (tx_en && level != '0 && !tx_busy) begin
                    pop_go    = 1'b1;
                    state_nxt = START;
                end
            end
            START: state_nxt = ACK;
            ACK:   if (tx_busy)  state_nxt = BUSY;
            BUSY:  if (!tx_busy) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Registered strobes: the show-ahead head is latched into tx_data at the
    // pop decision, so the byte stays stable for the whole frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fifo_rd_en <= 1'b0;
            tx_start   <= 1'b0;
            tx_data    <= '0;
        end else begin
            fifo_rd_en <= pop_go;
            tx_start   <= pop_go;
            if (pop_go) tx_data <= fifo_dout;
        end
    end

    // Sticky consistency flag: our count says bytes exist but the FIFO
    // reports empty at the moment we pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                    err <= 1'b0;
        else if (pop_go && fifo_empty) err <= 1'b1;
    end

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// Bench for uart_tx_fifo_ctrl: attached FIFO and transmitter models, a
// cycle-table for arbitration, hand sequences for the multi-cycle corners and
// a randomized run against a queue-based reference model.
module tb_uart_tx_fifo_ctrl;
    localparam int DW = 8;
    localparam int DEPTH = 16;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          tx_en = 1'b0;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic [DW-1:0] req0_data = '0, req1_data = '0;
    logic          req0_ready, req1_ready;
    logic          fifo_wr_en, fifo_rd_en;
    logic [DW-1:0] fifo_din;
    logic [DW-1:0] fifo_dout = '0;
    logic          fifo_empty_m = 1'b1;
    logic          fake_empty = 1'b0;
    logic          fifo_empty;
    logic          tx_start;
    logic [DW-1:0] tx_data;
    logic          tx_busy;
    logic          busy_a = 1'b0, busy_man = 1'b0, tx_auto = 1'b1;
    int            busy_cnt = 0;
    int            frame_len = 10;
    logic [LW-1:0] level;
    logic          err;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] fq[$];
    logic [DW-1:0] got[$];

    assign fifo_empty = fifo_empty_m | fake_empty;
    assign tx_busy    = tx_auto ? busy_a : busy_man;

    uart_tx_fifo_ctrl #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .tx_en(tx_en),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din), .fifo_rd_en(fifo_rd_en),
        .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
        .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
        .level(level), .err(err)
    );

    always #5 clk = ~clk;

    // Show-ahead FIFO model sharing the controller reset.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            fq.delete();
            fifo_dout    <= '0;
            fifo_empty_m <= 1'b1;
        end else begin
            if (fifo_rd_en && fq.size() != 0) void'(fq.pop_front());
            if (fifo_wr_en) fq.push_back(fifo_din);
            fifo_dout    <= (fq.size() != 0) ? fq[0] : '0;
            fifo_empty_m <= (fq.size() == 0);
        end
    end

    // Transmitter model: busy rises the cycle after tx_start and stays high
    // for frame_len cycles (random 2..7 when frame_len is 0). Not reset.
    always @(posedge clk) begin
        if (tx_start) begin
            got.push_back(tx_data);
            busy_a   <= 1'b1;
            busy_cnt <= (frame_len == 0) ? int'($urandom_range(1, 6)) : frame_len - 1;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end else begin
            busy_a <= 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; tx_en = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    typedef struct {
        logic          v0, v1;
        logic [DW-1:0] d0, d1;
        logic          r0, r1;
        logic [DW-1:0] din;
        int            lvl;
    } vec_t;

    vec_t vt[9];

    // Reference-model state for the random run.
    int            m_lvl, m_rr, base;
    logic [DW-1:0] m_q[$];
    logic          frame_open, seen_busy, e_start, decide, e_r0, e_r1;
    logic [DW-1:0] e_byte, e_byte_n;
    int            fires;

    initial begin
        // rr starts at req0; each row is one cycle, level is the pre-edge value.
        vt[0] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 0};
        vt[1] = '{1'b1, 1'b0, 8'h11, 8'h00, 1'b1, 1'b0, 8'h11, 0};
        vt[2] = '{1'b1, 1'b1, 8'h22, 8'h33, 1'b0, 1'b1, 8'h33, 1};
        vt[3] = '{1'b1, 1'b1, 8'h44, 8'h55, 1'b1, 1'b0, 8'h44, 2};
        vt[4] = '{1'b0, 1'b1, 8'h00, 8'h66, 1'b0, 1'b1, 8'h66, 3};
        vt[5] = '{1'b0, 1'b1, 8'h00, 8'h77, 1'b0, 1'b1, 8'h77, 4};
        vt[6] = '{1'b1, 1'b1, 8'h88, 8'h99, 1'b1, 1'b0, 8'h88, 5};
        vt[7] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 6};
        vt[8] = '{1'b1, 1'b1, 8'hAA, 8'hBB, 1'b0, 1'b1, 8'hBB, 6};

        // Reset held with requesters asking: nothing may be accepted.
        reset = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1; tx_en = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_r0", 32'(req0_ready), 0);
        chk("rst_r1", 32'(req1_ready), 0);
        chk("rst_wr", 32'(fifo_wr_en), 0);
        chk("rst_rd", 32'(fifo_rd_en), 0);
        chk("rst_start", 32'(tx_start), 0);
        chk("rst_lvl", 32'(level), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_txd", 32'(tx_data), 0);
        @(posedge clk); #1;

        // Arbitration table.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            req0_valid = vt[i].v0; req1_valid = vt[i].v1;
            req0_data  = vt[i].d0; req1_data  = vt[i].d1;
            @(negedge clk);
            chk($sformatf("tbl%0d_r0", i), 32'(req0_ready), 32'(vt[i].r0));
            chk($sformatf("tbl%0d_r1", i), 32'(req1_ready), 32'(vt[i].r1));
            chk($sformatf("tbl%0d_wr", i), 32'(fifo_wr_en), 32'(vt[i].r0 | vt[i].r1));
            if (vt[i].r0 | vt[i].r1) chk($sformatf("tbl%0d_din", i), 32'(fifo_din), 32'(vt[i].din));
            chk($sformatf("tbl%0d_lvl", i), 32'(level), 32'(vt[i].lvl));
            @(posedge clk); #1;
        end

        // Fairness: both valid for 6 cycles alternate 0,1,0,1,0,1.
        do_reset();
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("fair%0d_r0", i), 32'(req0_ready), 32'(i % 2 == 0));
            chk($sformatf("fair%0d_r1", i), 32'(req1_ready), 32'(i % 2 == 1));
            @(posedge clk); #1;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        chk("fair_lvl", 32'(level), 6);
        @(posedge clk); #1;

        // Cap at FIFO_DEPTH-1.
        do_reset();
        req0_valid = 1'b1; fires = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req0_ready) fires++;
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("cap_writes", 32'(fires), DEPTH - 1);
        chk("cap_ready", 32'(req0_ready), 0);
        chk("cap_wr", 32'(fifo_wr_en), 0);
        chk("cap_lvl", 32'(level), DEPTH - 1);
        @(posedge clk); #1;

        // Drain two bytes through 10-cycle frames.
        do_reset();
        tx_auto = 1'b1; frame_len = 10;
        req0_valid = 1'b1; req0_data = 8'h55;
        @(posedge clk); #1;
        req0_data = 8'hA3;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        base = got.size();
        tx_en = 1'b1;
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("drain_cnt", 32'(got.size() - base), 2);
        if (got.size() >= base + 2) begin
            chk("drain_b0", 32'(got[base]), 32'h55);
            chk("drain_b1", 32'(got[base+1]), 32'hA3);
        end
        chk("drain_lvl", 32'(level), 0);
        chk("drain_txd", 32'(tx_data), 32'hA3);
        @(posedge clk); #1;

        // Latency, simultaneous write+pop, then async reset in BUSY.
        do_reset();
        tx_en = 1'b1; req0_valid = 1'b1; req0_data = 8'h10;
        @(negedge clk);
        chk("lat_r0", 32'(req0_ready), 1);
        @(posedge clk); #1;
        req0_data = 8'h20;
        @(negedge clk);
        chk("lat_lvl1", 32'(level), 1);
        chk("lat_nostart", 32'(tx_start), 0);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(negedge clk);
        chk("lat_start", 32'(tx_start), 1);
        chk("lat_rd", 32'(fifo_rd_en), 1);
        chk("lat_txd", 32'(tx_data), 32'h10);
        chk("sim_lvl_pre", 32'(level), 2);
        req0_valid = 1'b1; req0_data = 8'h30;
        #1 chk("sim_wr", 32'(fifo_wr_en), 1);
        @(posedge clk); #1;
        req0_data = 8'h40;
        @(negedge clk);
        chk("sim_lvl_post", 32'(level), 2);
        chk("sim_start_pulse", 32'(tx_start), 0);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(negedge clk);
        chk("busy_lvl", 32'(level), 3);
        #2 reset = 1'b0;
        #1;
        chk("arst_lvl", 32'(level), 0);
        chk("arst_start", 32'(tx_start), 0);
        chk("arst_txd", 32'(tx_data), 0);
        @(posedge clk); #1;
        reset = 1'b1;
        base = got.size();
        repeat (25) @(posedge clk);
        @(negedge clk);
        chk("arst_no_start", 32'(got.size() - base), 0);
        chk("arst_lvl_hold", 32'(level), 0);
        @(posedge clk); #1;

        // err: FIFO claims empty at a pop decision.
        do_reset();
        frame_len = 3;
        req0_valid = 1'b1; req0_data = 8'h5A;
        @(posedge clk); #1;
        req0_valid = 1'b0; fake_empty = 1'b1; tx_en = 1'b1;
        @(negedge clk);
        chk("err_pre", 32'(err), 0);
        @(posedge clk); #1;
        fake_empty = 1'b0;
        @(negedge clk);
        chk("err_set", 32'(err), 1);
        repeat (15) @(posedge clk);
        @(negedge clk);
        chk("err_sticky", 32'(err), 1);
        chk("err_lvl", 32'(level), 0);
        @(posedge clk); #1;

        // Random run against the reference model.
        do_reset();
        frame_len = 0;
        m_lvl = 0; m_rr = 0; m_q.delete();
        frame_open = 1'b0; seen_busy = 1'b0; e_start = 1'b0; e_byte = '0; e_byte_n = '0;
        for (int c = 0; c < 600; c++) begin
            req0_valid = 1'($urandom_range(0, 1));
            req1_valid = 1'($urandom_range(0, 1));
            req0_data  = 8'($urandom);
            req1_data  = 8'($urandom);
            tx_en      = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            e_r0 = (m_lvl < DEPTH - 1) && req0_valid && (!req1_valid || m_rr == 0);
            e_r1 = (m_lvl < DEPTH - 1) && req1_valid && (!req0_valid || m_rr == 1);
            chk("rnd_r0", 32'(req0_ready), 32'(e_r0));
            chk("rnd_r1", 32'(req1_ready), 32'(e_r1));
            if (e_r0 || e_r1) chk("rnd_din", 32'(fifo_din), 32'(e_r0 ? req0_data : req1_data));
            chk("rnd_lvl", 32'(level), 32'(m_lvl));
            chk("rnd_start", 32'(tx_start), 32'(e_start));
            chk("rnd_rd", 32'(fifo_rd_en), 32'(e_start));
            if (e_start) chk("rnd_txd", 32'(tx_data), 32'(e_byte));
            chk("rnd_err", 32'(err), 0);
            // A new frame may begin once the previous one has been seen busy
            // and then idle; the start cycle itself does not watch busy.
            decide = !frame_open && tx_en && m_lvl != 0 && !tx_busy;
            if (frame_open && !e_start) begin
                if (!seen_busy)    seen_busy = tx_busy;
                else if (!tx_busy) frame_open = 1'b0;
            end
            if (decide) begin
                e_byte_n = m_q[0];
                frame_open = 1'b1;
                seen_busy = 1'b0;
            end
            if (e_start) void'(m_q.pop_front());
            if (e_r0) m_q.push_back(req0_data);
            else if (e_r1) m_q.push_back(req1_data);
            m_lvl = m_lvl + int'(e_r0 | e_r1) - int'(e_start);
            if (e_r0) m_rr = 1;
            else if (e_r1) m_rr = 0;
            e_start = decide;
            if (decide) e_byte = e_byte_n;
            @(posedge clk); #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
